noise_var_ctrl: RTL and testbench
=================================

# noise_var_ctrl

Sequencer for the combinational noise-variance engine. Gathers a window of `WIN_LEN` signed 13-bit samples from the receive datapath and feeds them to the engine, one `eng_ready` pulse per sample. It then strobes `eng_done`, waits for `eng_standby`, and publishes the result on `var_out`/`var_valid`. It sits between the ADC/filter sample stream and the downstream threshold logic, and supports one-shot or continuous measurement.

## Interface
- `WIN_LEN`, 64: samples per window, range 1..256 (engine array depth).
- `DONE_CYC`, 2: cycles `eng_done` is held high.
- `TIMEOUT`, 32: max cycles waiting for `eng_standby`.
- `ALPHA_SHIFT`, 2: smoothing shift, used only with `NOISE_CTRL_IIR_EN`.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a measurement (sampled in IDLE).
- `continuous` in 1: re-arm after each result.
- `abort` in 1: terminate the current window.
- `sample_in` in 13: signed sample.
- `sample_valid` in 1: `sample_in` valid.
- `in_ready` out 1: sample accepted when `sample_valid && in_ready`.
- `eng_sample` out 13: registered sample to the engine `signal_in`.
- `eng_ready` out 1: one-cycle accumulate pulse to the engine.
- `eng_done` out 1: compute/flush strobe to the engine.
- `eng_standby` in 1: engine idle/result-stable flag.
- `eng_var` in 13: engine result (signed).
- `var_out` out 13: published variance.
- `var_valid` out 1: one-cycle pulse when `var_out` updates.
- `busy` out 1: high in any state other than IDLE.
- `err_timeout` out 1: sticky; cleared by `start` accepted in IDLE.

## Operation
- **States:** IDLE, COLLECT, FLUSH, WAIT_RES, PUBLISH.
- **IDLE → COLLECT:** on `start`. Clears the sample count and `err_timeout`.
- **COLLECT, input handshake:**
  - `in_ready` is high when the count is below `WIN_LEN` and `eng_ready` was low the previous cycle. Maximum rate is therefore one sample per 2 cycles; the engine is level-sensitive, so `eng_ready` must toggle between samples.
  - On accept: `eng_sample` ← `sample_in`, `eng_ready` = 1 for the next cycle only, count increments.
  - `eng_sample` holds its value until the next accept.
- **COLLECT → FLUSH:** the cycle after the `WIN_LEN`-th `eng_ready` pulse.
- **FLUSH:** `eng_done` high for `DONE_CYC` cycles, `eng_ready` low, then → WAIT_RES.
- **WAIT_RES:** `eng_done` low.
  - First cycle with `eng_standby` = 1: capture `eng_var` → PUBLISH.
  - `TIMEOUT` cycles without `eng_standby`: `err_timeout` = 1 → IDLE, no publish.
- **PUBLISH:** update `var_out` and pulse `var_valid` for 1 cycle. Next state is COLLECT (count cleared) if `continuous`, else IDLE.
- **Result clamp:** a negative `eng_var` is engine overflow and is clamped to +4095 before publishing.
- **abort:**
  - In COLLECT with count > 0: go to FLUSH, because the engine must clear its accumulator. The result is discarded (WAIT_RES → IDLE, no `var_valid`).
  - In COLLECT with count = 0: go directly to IDLE.
  - In FLUSH/WAIT_RES: mark the result discard-only.
  - In IDLE: no effect.
- **Simultaneous events:**
  - `abort` has priority over a sample accept in the same cycle; the sample is not taken.
  - `start` outside IDLE is ignored.
  - `continuous` is sampled in PUBLISH only.

## Timing
- **Reset values:** all outputs 0 (`in_ready`, `eng_sample`, `eng_ready`, `eng_done`, `var_out`, `var_valid`, `busy`, `err_timeout`). State = IDLE, count = 0.
- **Reset mid-operation:** outputs drop immediately, with no flush.
- **Earliest timing:**
  - `start` at cycle 0: `in_ready` at cycle 1.
  - Last accept at cycle t: `eng_ready` at t+1, `eng_done` at t+2..t+1+`DONE_CYC`.
  - With `eng_standby` already high: capture at t+2+`DONE_CYC`, `var_valid` at t+3+`DONE_CYC`.
- **Minimum window duration:** 2·`WIN_LEN` + `DONE_CYC` + 3 cycles.

## Configuration
- **`NOISE_CTRL_IIR_EN` defined:** `var_out` is smoothed.
  - The first result after reset, or after leaving IDLE, loads directly.
  - Later results: `var_out` ← `var_out` + ((new − `var_out`) >>> `ALPHA_SHIFT`).
  - The difference is computed in 14-bit signed with an arithmetic shift; the result saturates to 0..4095.
- **Undefined:** `var_out` = clamped raw `eng_var`, and no smoothing logic is compiled.

## Test plan
- **One-shot:** `WIN_LEN`=4; `start`, samples 10,−10,10,−10 back-to-back `valid`, engine model `eng_var`=100 → exactly 4 `eng_ready` pulses spaced ≥2 cycles, `eng_done` 2 cycles, `var_out`=100, one `var_valid`, then IDLE with `busy`=0.
- **Continuous + IIR:** `continuous`=1, IIR on, `ALPHA_SHIFT`=2, results 100 then 20 → `var_out` 100 then 80. With IIR off → 100 then 20.
- **Abort:** `abort` after the 2nd of 4 samples → `eng_done` still pulses, no `var_valid`, IDLE; the next `start` produces a clean window.
- **Timeout:** `eng_standby` held 0 → after 32 cycles in WAIT_RES `err_timeout`=1, IDLE, no `var_valid`; the next `start` clears it.
- **Overflow and reset:** `eng_var` = −5 → `var_out`=4095. `rst` asserted mid-COLLECT → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/noise_var_ctrl_if.sv
// noise_var_ctrl_if: sample stream, engine handshake and result bus of the
// noise-variance sequencer. The slave modport is the sequencer's view; the
// master modport is the surrounding datapath/engine view.
interface noise_var_ctrl_if;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [12:0] sample_in;
  logic        sample_valid;
  logic        in_ready;
  logic [12:0] eng_sample;
  logic        eng_ready;
  logic        eng_done;
  logic        eng_standby;
  logic [12:0] eng_var;
  logic [12:0] var_out;
  logic        var_valid;
  logic        busy;
  logic        err_timeout;

  modport master (
    output start, continuous, abort, sample_in, sample_valid,
    output eng_standby, eng_var,
    input  in_ready, eng_sample, eng_ready, eng_done,
    input  var_out, var_valid, busy, err_timeout
  );

  modport slave (
    input  start, continuous, abort, sample_in, sample_valid,
    input  eng_standby, eng_var,
    output in_ready, eng_sample, eng_ready, eng_done,
    output var_out, var_valid, busy, err_timeout
  );
endinterface

// File: rtl/noise_var_ctrl.sv
// noise_var_ctrl: sequencer for the combinational noise-variance engine.
// Collects WIN_LEN samples, feeds them to the engine one eng_ready pulse at a
// time, strobes eng_done, waits for eng_standby and publishes the clamped
// result. Optional smoothing of the published value is compiled in when the
// macro NOISE_CTRL_IIR_EN is defined.
module noise_var_ctrl #(
  parameter int unsigned WIN_LEN     = 64,
  parameter int unsigned DONE_CYC    = 2,
  parameter int unsigned TIMEOUT     = 32,
  parameter int unsigned ALPHA_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  noise_var_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;

  localparam int unsigned CNT_W = $clog2(WIN_LEN + 1);
  localparam int unsigned DC_W  = (DONE_CYC > 1) ? $clog2(DONE_CYC) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN_LEN);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DONE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [12:0]      RES_MAX  = 13'd4095;

  // Elaboration-time parameter range guard.
  if (WIN_LEN < 1 || WIN_LEN > 256 || DONE_CYC < 1 || TIMEOUT < 1 ||
      ALPHA_SHIFT > 12) begin : g_param_range
    $error("noise_var_ctrl: parameter out of supported range");
  end

  logic [2:0]       r_state;
  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [DC_W-1:0]  r_dcnt;
  logic [TO_W-1:0]  r_tocnt;
  logic [12:0]      r_eng_sample;
  logic             r_eng_ready;
  logic             r_discard;
  logic [12:0]      r_var_out;
  logic             r_err;

  logic        w_in_ready;
  logic        w_accept;
  logic        w_start_acc;
  logic        w_flush_last;
  logic        w_to_last;
  logic        w_drop;
  logic        w_capture;
  logic        w_timeout;
  logic [12:0] w_res_clamped;
  logic [12:0] w_var_next;

  // Abort wins over a sample presented in the same cycle, so it also masks
  // in_ready to keep the handshake honest.
  assign w_in_ready   = (r_state == S_COLLECT) && (r_count < CNT_FULL) &&
                        !r_eng_ready && !bus.abort;
  assign w_accept     = w_in_ready && bus.sample_valid;
  assign w_start_acc  = (r_state == S_IDLE) && bus.start;
  assign w_flush_last = (r_dcnt == DC_LAST);
  assign w_to_last    = (r_tocnt == TO_LAST);
  assign w_drop       = r_discard || bus.abort;
  assign w_capture    = (r_state == S_WAIT) && bus.eng_standby && !w_drop;
  assign w_timeout    = (r_state == S_WAIT) && !bus.eng_standby && w_to_last;

  // Negative engine output means overflow; report full scale instead.
  assign w_res_clamped = bus.eng_var[12] ? RES_MAX : bus.eng_var;

  // Next-state selection for the measurement sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_COLLECT;
      end
      S_COLLECT: begin
        // A partially filled accumulator must be flushed even when aborted.
        if (bus.abort) begin
          w_state_next = (r_count != '0) ? S_FLUSH : S_IDLE;
        end else if (r_eng_ready && (r_count == CNT_FULL)) begin
          w_state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_flush_last) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_standby) begin
          w_state_next = w_drop ? S_IDLE : S_PUBLISH;
        end else if (w_to_last) begin
          w_state_next = S_IDLE;
        end
      end
      S_PUBLISH: begin
        w_state_next = bus.continuous ? S_COLLECT : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Accepted-sample count; restarts for every new window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_start_acc || (r_state == S_PUBLISH)) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Length of the eng_done strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dcnt <= '0;
    end else if ((r_state != S_FLUSH) || w_flush_last) begin
      r_dcnt <= '0;
    end else begin
      r_dcnt <= r_dcnt + DC_W'(1);
    end
  end

  // Cycles spent waiting for eng_standby.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tocnt <= '0;
    end else if ((r_state != S_WAIT) || w_to_last) begin
      r_tocnt <= '0;
    end else begin
      r_tocnt <= r_tocnt + TO_W'(1);
    end
  end

  // Marks a window whose result must not be published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard <= 1'b0;
    end else if (w_start_acc) begin
      r_discard <= 1'b0;
    end else if (bus.abort && (((r_state == S_COLLECT) && (r_count != '0)) ||
                               (r_state == S_FLUSH) || (r_state == S_WAIT))) begin
      r_discard <= 1'b1;
    end
  end

  // Engine feed: registered sample plus a single-cycle accumulate pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eng_sample <= '0;
      r_eng_ready  <= 1'b0;
    end else begin
      r_eng_ready <= w_accept;
      if (w_accept) r_eng_sample <= bus.sample_in;
    end
  end

`ifdef NOISE_CTRL_IIR_EN
  logic               r_iir_loaded;
  logic signed [13:0] w_diff;
  logic signed [13:0] w_step;
  logic signed [14:0] w_sum;
  logic [12:0]        w_smoothed;

  // First-order smoothing toward the new result, saturated to 0..4095.
  always_comb begin
    w_diff = $signed({1'b0, w_res_clamped}) - $signed({1'b0, r_var_out});
    w_step = w_diff >>> ALPHA_SHIFT;
    w_sum  = $signed({2'b00, r_var_out}) + 15'(w_step);
    if (w_sum < 0) begin
      w_smoothed = '0;
    end else if (w_sum > 15'sd4095) begin
      w_smoothed = RES_MAX;
    end else begin
      w_smoothed = w_sum[12:0];
    end
    w_var_next = r_iir_loaded ? w_smoothed : w_res_clamped;
  end

  // The first result of a run loads unsmoothed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iir_loaded <= 1'b0;
    end else if (w_start_acc) begin
      r_iir_loaded <= 1'b0;
    end else if (w_capture) begin
      r_iir_loaded <= 1'b1;
    end
  end
`else
  assign w_var_next = w_res_clamped;
`endif

  // Published result, updated on capture so it is stable with var_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_var_out <= '0;
    end else if (w_capture) begin
      r_var_out <= w_var_next;
    end
  end

  // Sticky timeout flag, cleared when a new measurement is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.eng_sample  = r_eng_sample;
  assign bus.eng_ready   = r_eng_ready;
  assign bus.eng_done    = (r_state == S_FLUSH);
  assign bus.var_out     = r_var_out;
  assign bus.var_valid   = (r_state == S_PUBLISH);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err_timeout = r_err;

endmodule

// File: tb/tb_noise_var_ctrl.sv
// tb_noise_var_ctrl: randomized scoreboard bench for noise_var_ctrl with a
// small engine model driving eng_standby/eng_var.
module tb_noise_var_ctrl;
  localparam int W  = 4;
  localparam int D  = 2;
  localparam int TO = 32;
  localparam int AS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  noise_var_ctrl_if bus();

  noise_var_ctrl #(
    .WIN_LEN(W), .DONE_CYC(D), .TIMEOUT(TO), .ALPHA_SHIFT(AS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int          exp_q[$];
  logic [12:0] samp_q[$];
  int          res_q[$];

  int   vv_cnt = 0, er_cnt = 0, done_pulses = 0, done_run = 0;
  int   last_vv_cyc = 0, last_er_cyc = -100, last_done_cyc = 0, start_cyc = 0;
  logic prev_err = 1'b0;

  bit sb_en    = 1'b1;
  int sb_delay = 0;
  int sb_cnt   = 100;

  int m_var   = 0;
  bit m_first = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: clamp overflow to full scale, optional smoothing with
  // new = old + floor((x - old) / 2^AS), first result of a run loads directly.
  function automatic int model(input int raw);
    int c;
    c = (raw < 0) ? 4095 : raw;
`ifdef NOISE_CTRL_IIR_EN
    if (m_first) begin
      m_var   = c;
      m_first = 1'b0;
    end else begin
      m_var = m_var + ((c - m_var) >>> AS);
      if (m_var < 0)    m_var = 0;
      if (m_var > 4095) m_var = 4095;
    end
    return m_var;
`else
    return c;
`endif
  endfunction

  // Engine model: result becomes stable sb_delay cycles after the flush.
  always @(negedge clk) begin
    if (bus.eng_done) sb_cnt = 0;
    else if (sb_cnt < 1000) sb_cnt++;
    bus.eng_standby = sb_en && (sb_cnt > sb_delay);
  end

  // Monitor: pops expected samples/results whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.eng_ready) begin
        check("eng_ready_gap", int'(cyc - last_er_cyc >= 2), 1);
        last_er_cyc = cyc;
        er_cnt++;
        check("eng_sample_queue_nonempty", int'(samp_q.size() > 0), 1);
        if (samp_q.size() > 0) check("eng_sample", bus.eng_sample, samp_q.pop_front());
      end
      if (bus.eng_done) begin
        done_run++;
        last_done_cyc = cyc;
      end else if (done_run > 0) begin
        check("eng_done_len", done_run, D);
        done_pulses++;
        done_run = 0;
      end
      if (bus.var_valid) begin
        vv_cnt++;
        last_vv_cyc = cyc;
        check("var_valid_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("var_out", bus.var_out, exp_q.pop_front());
      end
      if (bus.err_timeout && !prev_err) check("timeout_latency", cyc - last_done_cyc, TO + 1);
      prev_err = bus.err_timeout;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"},    bus.in_ready,    0);
    check({tag, "_eng_sample"},  bus.eng_sample,  0);
    check({tag, "_eng_ready"},   bus.eng_ready,   0);
    check({tag, "_eng_done"},    bus.eng_done,    0);
    check({tag, "_var_out"},     bus.var_out,     0);
    check({tag, "_var_valid"},   bus.var_valid,   0);
    check({tag, "_busy"},        bus.busy,        0);
    check({tag, "_err_timeout"}, bus.err_timeout, 0);
  endtask

  task automatic start_window();
    @(negedge clk);
    bus.start = 1'b1;
    start_cyc = cyc;
    m_first   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("start_busy", bus.busy, 1);
    check("start_in_ready", bus.in_ready, 1);
    check("start_err_cleared", bus.err_timeout, 0);
  endtask

  // Offer samples until n are accepted; abort_at >= 0 aborts after that many.
  task automatic feed(input int n, input int abort_at, input bit gaps);
    int accepted = 0;
    int budget   = 0;
    while (accepted < n && budget < 400) begin
      if (accepted == abort_at) begin
        bus.sample_valid = 1'b0;
        bus.start        = 1'b0;
        @(negedge clk);
        bus.sample_in    = 13'($urandom);
        bus.sample_valid = 1'b1;
        bus.abort        = 1'b1;
        @(negedge clk);
        bus.abort        = 1'b0;
        bus.sample_valid = 1'b0;
        break;
      end
      bus.sample_in    = 13'($urandom);
      bus.sample_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.start        = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
      #1;
      if (bus.sample_valid && bus.in_ready) begin
        samp_q.push_back(bus.sample_in);
        accepted++;
      end
      @(negedge clk);
      budget++;
    end
    bus.sample_valid = 1'b0;
    bus.start        = 1'b0;
    check("feed_accepted", accepted, (abort_at >= 0) ? abort_at : n);
  endtask

  task automatic wait_vv(input int v0, input int budget);
    int n = 0;
    while (vv_cnt == v0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("var_valid_count", vv_cnt - v0, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("returns_idle", bus.busy, 0);
  endtask

  // Runs nwin back-to-back windows (continuous between them) from res_q.
  task automatic run_windows(input int nwin, input bit gaps, input int sbd);
    int res, v0, e0;
    sb_delay       = sbd;
    sb_en          = 1'b1;
    bus.continuous = (nwin > 1);
    start_window();
    for (int w = 0; w < nwin; w++) begin
      res            = res_q.pop_front();
      bus.eng_var    = 13'(res);
      exp_q.push_back(model(res));
      bus.continuous = (w < nwin - 1);
      v0 = vv_cnt;
      e0 = er_cnt;
      feed(W, -1, gaps);
      wait_vv(v0, 300);
      check("eng_ready_pulses", er_cnt - e0, W);
    end
    wait_idle(50);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, d0;
    bus.start = 1'b0; bus.continuous = 1'b0; bus.abort = 1'b0;
    bus.sample_in = '0; bus.sample_valid = 1'b0; bus.eng_var = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 0);

    // One-shot window at full rate with the engine already idle
    d0 = done_pulses; v0 = vv_cnt;
    res_q = '{100};
    run_windows(1, 1'b0, 0);
    check("oneshot_latency", last_vv_cyc - start_cyc, 2 * W + D + 2);
    check("oneshot_done_pulses", done_pulses - d0, 1);
    check("oneshot_vv_pulses", vv_cnt - v0, 1);

    // Continuous pair: 100 then 20
    res_q = '{100, 20};
    run_windows(2, 1'b0, 0);

    // Abort after the 2nd sample: flush still happens, nothing published
    d0 = done_pulses; v0 = vv_cnt;
    bus.eng_var = 13'd777;
    start_window();
    feed(W, 2, 1'b0);
    wait_idle(100);
    check("abort_done_pulses", done_pulses - d0, 1);
    check("abort_no_publish", vv_cnt - v0, 0);
    check("abort_samples_drained", samp_q.size(), 0);

    // Abort before any sample: straight back to IDLE without a flush
    d0 = done_pulses;
    start_window();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_empty_idle", bus.busy, 0);
    repeat (4) @(negedge clk);
    check("abort_empty_no_flush", done_pulses - d0, 0);

    // Clean window after aborts
    res_q = '{300};
    run_windows(1, 1'b1, 3);

    // Timeout: engine never reports standby
    v0 = vv_cnt;
    sb_en = 1'b0;
    start_window();
    feed(W, -1, 1'b1);
    wait_idle(200);
    check("timeout_err", bus.err_timeout, 1);
    check("timeout_no_publish", vv_cnt - v0, 0);

    // Next start clears the error; overflow result clamps to full scale
    res_q = '{-5};
    run_windows(1, 1'b0, 0);

    // Asynchronous reset in the middle of a window
    start_window();
    feed(2, -1, 1'b0);
    #2 rst = 1'b1;
    #1 check_zero("async_reset");
    samp_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    res_q = '{55};
    run_windows(1, 1'b1, 0);

    // Randomized continuous runs
    repeat (3) begin
      for (int k = 0; k < 3; k++) res_q.push_back(int'($urandom_range(0, 8191)) - 4096);
      run_windows(3, 1'b1, int'($urandom_range(0, 20)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    check("sample_queue_empty", samp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
